key_input: RTL and testbench
============================

# key_input

Per-key debouncer, edge detector and auto-repeater for the active-low DE-series pushbuttons. It sits directly upstream of the memory-editing controller: the raw `KEY` pins go in, and clean `press` pulses come out, so the controller performs exactly one increment, decrement or address step per physical press. Held keys auto-repeat, so a value or address can be swept without repeated presses.

## Interface
Parameters:
- `NKEYS`, 4: number of independent key channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Must be ≥1.
- `REPEAT_DELAY`, 25000000: cycles from the initial press pulse to the first repeat pulse. 0 disables auto-repeat.
- `REPEAT_PERIOD`, 5000000: cycles between successive repeat pulses. Must be ≥1.

Ports:
- `clk`, in, 1: system clock. One clock; all state is clocked on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `KEY`, in, `NKEYS`: raw pushbuttons, active-low (0 = pressed), asynchronous to `clk`.
- `pressed`, out, `NKEYS`: debounced level, active-high. Reset value 0.
- `press`, out, `NKEYS`: single-cycle pulse on an accepted press and on each repeat. Reset value 0.

## Operation
- Channels are fully independent; simultaneous events on different keys are legal and produce simultaneous outputs.
- Per channel:
  - A two-flop synchronizer inverts `KEY[i]` to active-high `s`. Both flops reset to 0 (released).
  - `stable` holds the accepted level, reset value 0. `pressed[i]` = `stable`.
- Debounce:
  - Counter `dcnt` increments each cycle that `s != stable`.
  - Any cycle with `s == stable` clears `dcnt` to 0, so a bounce restarts the count.
  - When `s != stable` and `dcnt == DEBOUNCE_CYCLES-1`, `stable` toggles and `dcnt` clears.
- Per-channel state machine, states `UP`, `DOWN_WAIT`, `DOWN_REPEAT`:
  - `UP` → `DOWN_WAIT` when `stable` rises; `press` pulses that cycle; `rcnt` clears.
  - `DOWN_WAIT`: `rcnt` counts up. At `rcnt == REPEAT_DELAY-1`: pulse `press`, clear `rcnt`, go to `DOWN_REPEAT`. With `REPEAT_DELAY == 0`, stay in `DOWN_WAIT` and never pulse.
  - `DOWN_REPEAT`: `rcnt` counts up. At `rcnt == REPEAT_PERIOD-1`: pulse `press` and clear `rcnt`.
  - Any state → `UP` when `stable` falls. No pulse on release; `rcnt` clears.
- Counter width: `$clog2` of the maximum of `DEBOUNCE_CYCLES`, `REPEAT_DELAY` and `REPEAT_PERIOD`, plus 1. Counters must never wrap; they saturate at their compare points by construction.
- Reset asserted at any time clears all state and outputs immediately, including mid-debounce and mid-repeat.
- A key held low across reset deassertion is debounced from scratch and produces a normal press.

## Timing
- Let edge k be the first clock edge that samples `KEY[i]` low, with the key held thereafter.
- `pressed[i]` rises and `press[i]` pulses at edge k+1+`DEBOUNCE_CYCLES`. The pulse is high for exactly one cycle.
- Let p be the edge of the initial press pulse. Repeat pulses occur at p+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles after that, while `stable` = 1.
- Release: let r be the first edge sampling `KEY[i]` high. `pressed[i]` falls at edge r+1+`DEBOUNCE_CYCLES`. No repeat pulse can occur on or after the edge where `stable` falls.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `pressed` and never pulses `press`.
- Outputs are registered: no combinational path from `KEY` to any output.

## Structure
- Package `key_input_pkg`:
  - `typedef enum logic [1:0] {UP, DOWN_WAIT, DOWN_REPEAT} key_state_t`.
  - Default cycle-count constants for a 50 MHz clock.
- Sub-module `key_channel`: synchronizer, debounce counter, state machine and repeat counter for one key. `key_input` instantiates it `NKEYS` times in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
1. Clean press: `KEY[0]` sampled low at edge 10 and held → `pressed[0]` rises and one-cycle `press[0]` at edge 15. No other pulse before edge 25.
2. Bounce: `KEY[1]` low for 3 cycles, high for 1, then low from edge 20 → no pulse during the bounce. Single `press[1]` at edge 25.
3. Auto-repeat: hold `KEY[2]` with press at p=15 → `press[2]` pulses at 15, 25, 28, 31, 34. After release sampled at edge 35, `pressed[2]` falls at edge 40; the pulse at 37 still occurs because `stable` is still 1, and there is no pulse at 40 or later.
4. Release glitch: while `KEY[3]` is held, drive it high for 2 cycles → `pressed[3]` stays 1 and the repeat cadence is unaffected.
5. Simultaneous: `KEY[0]` and `KEY[3]` sampled low at the same edge → `press[0]` and `press[3]` pulse in the same cycle.
6. Reset mid-operation: assert `reset` asynchronously at edge 13 of scenario 1 → outputs are 0 immediately. With the key still low and first post-reset sampling edge q, `press[0]` pulses at q+5.

Source files
------------

// File: rtl/key_input_pkg.sv
// Shared types and default timing constants for the pushbutton front end.
// Defaults assume a 50 MHz system clock.
package key_input_pkg;

    typedef enum logic [1:0] {
        UP,
        DOWN_WAIT,
        DOWN_REPEAT
    } key_state_t;

    // 10 ms of stable level before a change is believed
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;
    // 0.5 s from the initial press pulse to the first repeat
    localparam int DEFAULT_REPEAT_DELAY    = 25_000_000;
    // 0.1 s between repeats once repeating has started
    localparam int DEFAULT_REPEAT_PERIOD   = 5_000_000;

    // Counter width large enough to reach the largest compare point without wrapping
    function automatic int count_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton channel: synchronizer, debouncer, press/repeat state machine.
// The raw key is active-low; everything downstream of the synchronizer is active-high.
module key_channel
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
)
(
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    localparam int CW = count_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    // Compare points; a zero repeat delay never reaches its compare, so clamp it
    localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST    = CW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [CW-1:0] PERIOD_LAST   = CW'(REPEAT_PERIOD - 1);

    logic          sync1;
    logic          s;
    logic          stable;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] rcnt;
    key_state_t    state;

    logic flip;
    logic rise;
    logic fall;

    // The accepted level changes on the cycle the disagreement count completes
    assign flip = (s != stable) && (dcnt == DEBOUNCE_LAST);
    assign rise = flip && !stable;
    assign fall = flip && stable;

    assign pressed = stable;

    // Two-flop synchronizer, inverting the active-low pin to active-high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            s     <= sync1;
        end
    end

    // Debounce: count consecutive disagreeing cycles, any agreement restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            dcnt   <= '0;
        end else if (s == stable) begin
            dcnt   <= '0;
        end else if (flip) begin
            stable <= ~stable;
            dcnt   <= '0;
        end else begin
            dcnt   <= dcnt + CW'(1);
        end
    end

    // Press and auto-repeat state machine; release always wins over a due repeat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UP;
            rcnt  <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (fall) begin
                state <= UP;
                rcnt  <= '0;
            end else begin
                case (state)
                    UP: begin
                        rcnt <= '0;
                        if (rise) begin
                            state <= DOWN_WAIT;
                            press <= 1'b1;
                        end
                    end
                    DOWN_WAIT: begin
                        if (REPEAT_DELAY == 0) begin
                            rcnt <= '0;
                        end else if (rcnt == DELAY_LAST) begin
                            press <= 1'b1;
                            rcnt  <= '0;
                            state <= DOWN_REPEAT;
                        end else begin
                            rcnt <= rcnt + CW'(1);
                        end
                    end
                    DOWN_REPEAT: begin
                        if (rcnt == PERIOD_LAST) begin
                            press <= 1'b1;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= UP;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_input.sv
// Pushbutton front end for the memory editor: one independent channel per key,
// turning raw active-low pins into a debounced level and press/repeat pulses.
module key_input
    import key_input_pkg::*;
#(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] KEY,
    output logic [NKEYS-1:0] pressed,
    output logic [NKEYS-1:0] press
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .key_n   (KEY[i]),
            .pressed (pressed[i]),
            .press   (press[i])
        );
    end

endmodule

// File: tb/tb_key_input.sv
// Scoreboard bench for key_input with short timing constants.
// A behavioural model predicts pressed/press for every cycle and queues the
// prediction; a monitor pops and compares against the DUT each cycle.
module tb_key_input;

    localparam int NK = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_drv;
    logic [NK-1:0] pressed;
    logic [NK-1:0] press;

    int total = 0;
    int bad   = 0;

    logic [2*NK-1:0] exp_q[$];

    // Model state: raw-sample history per key, accepted level, edge of the initial press
    bit win [NK][D+2];
    bit m_stable [NK];
    bit m_press [NK];
    int m_rise_edge [NK];
    int edge_n;

    key_input #(
        .NKEYS           (NK),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .KEY     (key_drv),
        .pressed (pressed),
        .press   (press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [NK-1:0] actual,
                               input logic [NK-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at t=%0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < NK; i++) begin
            for (int j = 0; j < D + 2; j++) win[i][j] = 1'b0;
            m_stable[i]    = 1'b0;
            m_press[i]     = 1'b0;
            m_rise_edge[i] = 0;
        end
        edge_n = 0;
    endtask

    // Reference model, evaluated at each rising edge from the levels the bench drove.
    // The key is accepted once its synchronized level (raw sample two edges back)
    // has disagreed with the accepted level for D edges in a row. Pulses fall at
    // the initial press edge p, at p+RD, and then every RP edges while held.
    initial begin
        modelClear();
        forever begin
            @(posedge clk);
            if (reset) begin
                modelClear();
            end else begin
                edge_n++;
                for (int i = 0; i < NK; i++) begin
                    bit all_diff;
                    int d;
                    for (int j = D + 1; j >= 1; j--) win[i][j] = win[i][j-1];
                    win[i][0] = ~key_drv[i];
                    all_diff = 1'b1;
                    for (int j = 2; j <= D + 1; j++)
                        if (win[i][j] == m_stable[i]) all_diff = 1'b0;
                    m_press[i] = 1'b0;
                    if (all_diff) begin
                        m_stable[i] = ~m_stable[i];
                        if (m_stable[i]) begin
                            m_rise_edge[i] = edge_n;
                            m_press[i]     = 1'b1;
                        end
                    end else if (m_stable[i]) begin
                        d = edge_n - m_rise_edge[i];
                        if (d == RD || (d > RD && ((d - RD) % RP) == 0))
                            m_press[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Publish the expected outputs for the current cycle into the scoreboard
    initial begin
        forever begin
            logic [2*NK-1:0] e;
            @(negedge clk);
            e = '0;
            if (reset) begin
                modelClear();
            end else begin
                for (int i = 0; i < NK; i++) begin
                    e[NK+i] = m_stable[i];
                    e[i]    = m_press[i];
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pop each cycle's prediction and compare with what the DUT presents
    initial begin
        forever begin
            logic [2*NK-1:0] e;
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard_empty at t=%0t: got 0 entries expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pressed", pressed, e[2*NK-1:NK]);
                checkOutput("press", press, e[NK-1:0]);
            end
        end
    end

    // Drive the raw (active-low) keys for a number of rising edges
    task automatic applyStimulus(input logic [NK-1:0] keys, input int cycles);
        @(negedge clk);
        key_drv = keys;
        repeat (cycles) @(posedge clk);
    endtask

    // Assert reset between edges, confirm outputs clear at once, release later
    task automatic applyReset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_async_pressed", pressed, '0);
        checkOutput("reset_async_press", press, '0);
        @(negedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        int rem [NK];
        logic [NK-1:0] k;

        reset   = 1'b1;
        key_drv = '1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state_pressed", pressed, '0);
        checkOutput("reset_state_press", press, '0);
        @(negedge clk);
        #3;
        reset = 1'b0;

        $display("[TB] directed scenarios");
        // Clean press on key 0
        applyStimulus(4'b1110, 20);
        applyStimulus(4'b1111, 10);
        // Bounce on key 1, then a real press
        applyStimulus(4'b1101, 3);
        applyStimulus(4'b1111, 1);
        applyStimulus(4'b1101, 15);
        applyStimulus(4'b1111, 10);
        // Long hold on key 2 through several repeats, released mid-cadence
        applyStimulus(4'b1011, 25);
        applyStimulus(4'b1111, 10);
        // Release glitch on key 3 while repeating
        applyStimulus(4'b0111, 15);
        applyStimulus(4'b1111, 2);
        applyStimulus(4'b0111, 15);
        applyStimulus(4'b1111, 10);
        // Simultaneous press on keys 0 and 3
        applyStimulus(4'b0110, 8);
        applyStimulus(4'b1111, 10);
        // Reset mid-debounce with the key still held, then mid-repeat
        applyStimulus(4'b1110, 3);
        applyReset();
        applyStimulus(4'b1110, 20);
        applyReset();
        applyStimulus(4'b1110, 10);
        applyStimulus(4'b1111, 10);

        $display("[TB] randomized phase");
        k = '1;
        for (int i = 0; i < NK; i++) rem[i] = $urandom_range(1, 20);
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (rem[i] == 0) begin
                    k[i] = ~k[i];
                    if ($urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 3);
                    else                           rem[i] = $urandom_range(5, 30);
                end else begin
                    rem[i]--;
                end
            end
            applyStimulus(k, 1);
            if (c == 350) applyReset();
        end

        applyStimulus(4'b1111, 12);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
